reset_sequencer: RTL

// - Parametrised multi-channel reset sequencer; successor to the N-stage reset synchroniser.
// - Holds CHANNELS active-high reset outputs for a minimum assertion time.
// - Then releases the outputs in ascending index order, STAGE_DELAY cycles apart.
// - Accepts a software reset request and an optional per-channel release acknowledge.
// - Sits after the reset synchroniser; drives MAC/PHY/FIFO domain resets in bring-up order.

---
 rtl/reset_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Multi-channel reset sequencer. It holds every reset output for a
//            minimum time and then releases the channels in ascending order.
//            Define RST_SEQ_ACK_EN to make each release wait for an ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_DELAY = 8,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst_req,
  input  logic [CHANNELS-1:0] ack_in,
  output logic [CHANNELS-1:0] rst_out,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int c_MAX_AB  = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
  localparam int c_MAX_CNT = (c_MAX_AB > ACK_TIMEOUT) ? c_MAX_AB : ACK_TIMEOUT;
  localparam int c_CW      = $clog2(c_MAX_CNT + 1);
  localparam int c_IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

`ifdef RST_SEQ_ACK_EN
  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_RELEASE  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RUN      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd3
  } state_t;
`endif

  state_t              r_state, w_state;
  logic [c_CW-1:0]     r_cnt, w_cnt;
  logic [c_IW-1:0]     r_idx, w_idx;
  logic [CHANNELS-1:0] r_rst_out, w_rst_out;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_terr, w_terr;
  logic                w_ack_sel;

  // ack_in bit of the most recently released channel
  always_comb begin
    w_ack_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (c_IW'(i) == r_idx) w_ack_sel = ack_in[i];
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_rst_out = r_rst_out;
    w_busy    = r_busy;
    w_done    = r_done;
    w_terr    = r_terr;
    if (sw_rst_req) begin
      w_state   = ST_ASSERT;
      w_cnt     = '0;
      w_idx     = '0;
      w_rst_out = '1;
      w_busy    = 1'b1;
      w_done    = 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (r_cnt == c_CW'(MIN_ASSERT - 1)) begin
            w_state = ST_RELEASE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + c_CW'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == c_CW'(STAGE_DELAY - 1)) begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (c_IW'(i) == r_idx) w_rst_out[i] = 1'b0;
            end
            w_cnt = '0;
            if (r_idx == c_IW'(CHANNELS - 1)) begin
              w_state = ST_RUN;
              w_done  = 1'b1;
              w_busy  = 1'b0;
            end else begin
`ifdef RST_SEQ_ACK_EN
              w_state = ST_WAIT_ACK;
`else
              w_idx = r_idx + c_IW'(1);
`endif
            end
          end else begin
            w_cnt = r_cnt + c_CW'(1);
          end
        end
`ifdef RST_SEQ_ACK_EN
        ST_WAIT_ACK: begin
          // An ack arriving on the timeout cycle wins; no error is flagged
          if (w_ack_sel || (r_cnt == c_CW'(ACK_TIMEOUT - 1))) begin
            if (!w_ack_sel) w_terr = 1'b1;
            w_state = ST_RELEASE;
            w_cnt   = '0;
            w_idx   = r_idx + c_IW'(1);
          end else begin
            w_cnt = r_cnt + c_CW'(1);
          end
        end
`endif
        ST_RUN: begin
          w_state = ST_RUN;
        end
        default: begin
          w_state = ST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_rst_out <= w_rst_out;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_terr    <= w_terr;
    end
  end

  assign rst_out = r_rst_out;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef RST_SEQ_ACK_EN
  assign timeout_err = r_terr;
`else
  // Without acknowledges nothing can time out
  logic w_unused_ack;
  assign w_unused_ack = ^{w_ack_sel, r_terr};
  assign timeout_err  = 1'b0;
`endif

endmodule

`default_nettype wire
